ram_scan_ctrl: RTL and testbench

Parametrised single-port RAM controller for the board-level memory exercises. It steps all RAM activity at a programmable slow rate derived from the system clock. Three modes are provided: manual switch-driven read/write, automatic address scan, and a self-running fill with completion handshake. Its `addr_o` and `q` outputs feed the hex-display digit splitters; `write_o` drives an LED.

---
 rtl/ram_scan_ctrl_if.sv | 38 +++
 rtl/ram_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ram_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_ctrl_if
// Purpose  : Bundles the mode/address/data controls and the access/status
//            outputs of ram_scan_ctrl into one interface.
// Ports    : mode, addr_in, data_in, wren, start  (controller inputs)
//            addr_o, q, write_o, tick_o, busy, done (controller outputs)
// Modports : master - drives the controls, observes the outputs
//            slave  - the controller side
// Revision : 1.0 - initial release
// ============================================================================
interface ram_scan_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              wren;
  logic              start;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] q;
  logic              write_o;
  logic              tick_o;
  logic              busy;
  logic              done;

  modport master (
    output mode, addr_in, data_in, wren, start,
    input  addr_o, q, write_o, tick_o, busy, done
  );

  modport slave (
    input  mode, addr_in, data_in, wren, start,
    output addr_o, q, write_o, tick_o, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_ctrl
// Purpose  : Single-port RAM controller stepped by a slow tick derived from
//            the system clock. Modes: manual read/write (00), address scan
//            (01), self-running fill with busy/done handshake (10), hold (11).
// Ports    : CLOCK_50 - system clock, rising edge
//            reset    - synchronous, active-high
//            bus      - ram_scan_ctrl_if.slave (controls in, access/status out)
// Revision : 1.0 - initial release
// ============================================================================
module ram_scan_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 25000000
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  ram_scan_ctrl_if.slave bus
);

  localparam int                c_DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W + 1)'(DEPTH);
  localparam int                c_WORDS   = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_DIV_W-1:0]  r_div;
  logic                w_tick;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_q;
  logic                r_write;
  logic                r_done;
  logic                w_fill_wr;
  logic                w_fill_last;
  logic [DATA_W-1:0]   w_fill_val;
  logic                w_addr_ok;
  logic [ADDR_W-1:0]   w_scan_addr;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Sized to the full address space so any ADDR_W-wide index is legal;
  // only words below DEPTH are ever written or read.
  logic [DATA_W-1:0]   r_mem [c_WORDS];

  // --------------------------------------------------------------------------
  // Step tick
  // --------------------------------------------------------------------------
  assign w_tick = (r_div == c_DIV_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Fill FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_wr   = 1'b0;
    w_fill_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.mode == 2'b10)) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (w_tick) begin
          w_fill_wr = 1'b1;
          if (r_ptr == c_LAST) begin
            w_fill_last = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Address/data helpers
  // --------------------------------------------------------------------------
  assign w_fill_val = bus.data_in + DATA_W'(r_ptr);
  assign w_addr_ok  = ({1'b0, bus.addr_in} < c_DEPTH);
  // A leftover out-of-range manual address restarts the scan at 0, same as wrap.
  assign w_scan_addr = (r_addr >= c_LAST) ? '0 : r_addr + 1'b1;

  // --------------------------------------------------------------------------
  // RAM write port (contents survive reset; a tick during reset never writes)
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_ptr;
    w_mem_wdata = w_fill_val;
    if (!reset) begin
      if (w_fill_wr) begin
        w_mem_we = 1'b1;
      end else if ((r_state == S_IDLE) && w_tick && (bus.mode == 2'b00) &&
                   bus.wren && w_addr_ok) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = bus.addr_in;
        w_mem_wdata = bus.data_in;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Access result registers and fill pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ptr   <= '0;
      r_addr  <= '0;
      r_q     <= '0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fill_last;
      if (r_state == S_FILL) begin
        if (w_fill_wr) begin
          r_addr  <= r_ptr;
          r_q     <= w_fill_val;
          r_write <= 1'b1;
          r_ptr   <= w_fill_last ? '0 : r_ptr + 1'b1;
        end
      end else begin
        // Pointer parked at 0 so every fill starts from the first word.
        r_ptr <= '0;
        if (w_tick) begin
          case (bus.mode)
            2'b00: begin
              r_addr <= bus.addr_in;
              if (!w_addr_ok) begin
                r_q     <= '0;
                r_write <= 1'b0;
              end else if (bus.wren) begin
                r_q     <= bus.data_in;
                r_write <= 1'b1;
              end else begin
                r_q     <= r_mem[bus.addr_in];
                r_write <= 1'b0;
              end
            end
            2'b01: begin
              r_addr  <= w_scan_addr;
              r_q     <= r_mem[w_scan_addr];
              r_write <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.addr_o  = r_addr;
  assign bus.q       = r_q;
  assign bus.write_o = r_write;
  assign bus.tick_o  = w_tick;
  assign bus.busy    = (r_state == S_FILL);
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_scan_ctrl
// Purpose  : Self-checking bench for ram_scan_ctrl. A per-tick reference
//            model (word array plus last-access record) predicts every access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_scan_ctrl;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 20;
  localparam int TICK_DIV = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] m_mem [2**ADDR_W];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_q;
  logic              m_wr;

  ram_scan_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_scan_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Advance to the negedge of the next tick cycle.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tick_o !== 1'b1 && n < TICK_DIV + 2);
    if (bus.tick_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: tick_o=%b after %0d cycles, required 1 within %0d",
               bus.tick_o, n, TICK_DIV);
    end
  endtask

  // Idle-state behaviour of one tick, straight from the mode rules.
  function automatic void model_idle(input logic [1:0] md, input logic [ADDR_W-1:0] a,
                                     input logic w, input logic [DATA_W-1:0] d);
    case (md)
      2'b00: begin
        m_addr = a;
        if (int'(a) < DEPTH) begin
          if (w) begin
            m_mem[a] = d;
            m_q      = d;
            m_wr     = 1'b1;
          end else begin
            m_q  = m_mem[a];
            m_wr = 1'b0;
          end
        end else begin
          m_q  = '0;
          m_wr = 1'b0;
        end
      end
      2'b01: begin
        m_addr = (int'(m_addr) >= DEPTH - 1) ? '0 : m_addr + 1'b1;
        m_q    = m_mem[m_addr];
        m_wr   = 1'b0;
      end
      default: begin
      end
    endcase
  endfunction

  // One idle-mode tick: drive controls, let the tick edge pass, update model.
  task automatic drive_tick(input logic [1:0] md, input logic [ADDR_W-1:0] a,
                            input logic w, input logic [DATA_W-1:0] d);
    wait_tick();
    bus.mode    = md;
    bus.addr_in = a;
    bus.wren    = w;
    bus.data_in = d;
    bus.start   = 1'b0;
    @(posedge clk);
    #1;
    model_idle(md, a, w, d);
  endtask

  task automatic fill_entry(input bit align, input logic [DATA_W-1:0] seed);
    bus.mode  = 2'b11;
    bus.start = 1'b0;
    bus.wren  = 1'b0;
    if (align) begin
      wait_tick();
    end else begin
      @(negedge clk);
      if (bus.tick_o === 1'b1) @(negedge clk);
    end
    bus.mode    = 2'b10;
    bus.start   = 1'b1;
    bus.data_in = seed;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_entry_busy: busy=%b, required 1 (align=%0d)", bus.busy, align);
    end
    checks++;
    if ({bus.addr_o, bus.q, bus.write_o} !== {m_addr, m_q, m_wr}) begin
      errors++;
      $display("FAIL fill_entry_noaccess: got addr=%0d q=%h wr=%b, required addr=%0d q=%h wr=%b",
               bus.addr_o, bus.q, bus.write_o, m_addr, m_q, m_wr);
    end
  endtask

  // Runs a fill already in progress; abort_at < DEPTH asserts reset on that word's tick.
  task automatic fill_run(input int abort_at, input bit keep_start, input bit rand_data);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      wait_tick();
      bus.start   = keep_start;
      bus.mode    = (keep_start && i == DEPTH - 1) ? 2'b10 : 2'($urandom_range(0, 3));
      bus.wren    = 1'($urandom);
      bus.addr_in = ADDR_W'($urandom);
      if (rand_data) bus.data_in = DATA_W'($urandom);
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.addr_o, bus.q, bus.write_o} !== '0) begin
          errors++;
          $display("FAIL reset_abort: busy=%b done=%b addr=%0d q=%h wr=%b, required all 0",
                   bus.busy, bus.done, bus.addr_o, bus.q, bus.write_o);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus.mode  = 2'b11;
        bus.start = 1'b0;
        m_addr    = '0;
        m_q       = '0;
        m_wr      = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_no_done: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
        return;
      end
      v         = bus.data_in + DATA_W'(i);
      m_mem[i]  = v;
      m_addr    = ADDR_W'(i);
      m_q       = v;
      m_wr      = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.addr_o, bus.q, bus.write_o} !== {m_addr, m_q, m_wr}) begin
        errors++;
        $display("FAIL fill_write[%0d]: got addr=%0d q=%h wr=%b, required addr=%0d q=%h wr=%b",
                 i, bus.addr_o, bus.q, bus.write_o, m_addr, m_q, m_wr);
      end
      checks++;
      if (bus.busy !== (i < DEPTH - 1) || bus.done !== (i == DEPTH - 1)) begin
        errors++;
        $display("FAIL fill_status[%0d]: busy=%b done=%b, required busy=%b done=%b",
                 i, bus.busy, bus.done, (i < DEPTH - 1), (i == DEPTH - 1));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== keep_start) begin
      errors++;
      $display("FAIL fill_after: done=%b busy=%b, required done=0 busy=%b",
               bus.done, bus.busy, keep_start);
    end
    if (!keep_start) begin
      bus.mode  = 2'b11;
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.mode    = 2'b11;
    bus.addr_in = '0;
    bus.data_in = '0;
    bus.wren    = 1'b0;
    bus.start   = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.addr_o, bus.q, bus.write_o, bus.tick_o, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d q=%h wr=%b tick=%b busy=%b done=%b, required all 0",
               bus.addr_o, bus.q, bus.write_o, bus.tick_o, bus.busy, bus.done);
    end
    reset  = 1'b0;
    m_addr = '0;
    m_q    = '0;
    m_wr   = 1'b0;
    // Cycle 1 is the first cycle with reset low.
    for (int c = 1; c <= 3 * TICK_DIV; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (bus.tick_o !== ((c % TICK_DIV) == 0)) begin
        errors++;
        $display("FAIL tick_period: cycle %0d tick_o=%b, required %b",
                 c, bus.tick_o, ((c % TICK_DIV) == 0));
      end
    end
  endtask

  task automatic test_fill_then_scan();
    fill_entry(1'b0, 8'hF0);
    fill_run(DEPTH, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive_tick(2'b01, ADDR_W'($urandom), 1'($urandom), DATA_W'($urandom));
      checks++;
      if ({bus.addr_o, bus.q, bus.write_o} !== {m_addr, m_q, m_wr}) begin
        errors++;
        $display("FAIL scan[%0d]: got addr=%0d q=%h wr=%b, required addr=%0d q=%h wr=%b",
                 i, bus.addr_o, bus.q, bus.write_o, m_addr, m_q, m_wr);
      end
    end
  endtask

  task automatic test_manual();
    drive_tick(2'b00, 5'd3, 1'b1, 8'hA5);
    checks++;
    if ({bus.addr_o, bus.q, bus.write_o} !== {5'd3, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL manual_write: got addr=%0d q=%h wr=%b, required addr=3 q=a5 wr=1",
               bus.addr_o, bus.q, bus.write_o);
    end
    drive_tick(2'b00, 5'd3, 1'b0, 8'h5A);
    checks++;
    if ({bus.addr_o, bus.q, bus.write_o} !== {5'd3, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL manual_readback: got addr=%0d q=%h wr=%b, required addr=3 q=a5 wr=0",
               bus.addr_o, bus.q, bus.write_o);
    end
    for (int i = 0; i < 24; i++) begin
      drive_tick(2'b00, ADDR_W'($urandom), 1'($urandom), DATA_W'($urandom));
      checks++;
      if ({bus.addr_o, bus.q, bus.write_o} !== {m_addr, m_q, m_wr}) begin
        errors++;
        $display("FAIL manual_random[%0d]: got addr=%0d q=%h wr=%b, required addr=%0d q=%h wr=%b",
                 i, bus.addr_o, bus.q, bus.write_o, m_addr, m_q, m_wr);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [ADDR_W-1:0] a_list [6] = '{5'd25, 5'd5, 5'(DEPTH - 1), 5'(DEPTH), 5'(DEPTH - 1), 5'd25};
    logic              w_list [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_tick(2'b00, a_list[i], w_list[i], (i == 0) ? 8'h77 : DATA_W'($urandom));
      checks++;
      if ({bus.addr_o, bus.q, bus.write_o} !== {m_addr, m_q, m_wr}) begin
        errors++;
        $display("FAIL range[%0d]: got addr=%0d q=%h wr=%b, required addr=%0d q=%h wr=%b",
                 i, bus.addr_o, bus.q, bus.write_o, m_addr, m_q, m_wr);
      end
    end
    // Scan from a leftover out-of-range address restarts at word 0.
    drive_tick(2'b01, '0, 1'b0, '0);
    checks++;
    if ({bus.addr_o, bus.q, bus.write_o} !== {5'd0, m_mem[0], 1'b0}) begin
      errors++;
      $display("FAIL range_scan_restart: got addr=%0d q=%h wr=%b, required addr=0 q=%h wr=0",
               bus.addr_o, bus.q, bus.write_o, m_mem[0]);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      drive_tick((i < 2) ? 2'b11 : 2'b10, ADDR_W'($urandom), 1'b1, DATA_W'($urandom));
      checks++;
      if ({bus.addr_o, bus.q, bus.write_o, bus.busy} !== {m_addr, m_q, m_wr, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got addr=%0d q=%h wr=%b busy=%b, required addr=%0d q=%h wr=%b busy=0",
                 i, bus.addr_o, bus.q, bus.write_o, bus.busy, m_addr, m_q, m_wr);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_entry(1'b0, DATA_W'($urandom));
    fill_run(DEPTH, 1'b1, 1'b1);
    fill_run(DEPTH, 1'b0, 1'b1);
  endtask

  task automatic test_start_on_tick();
    fill_entry(1'b1, DATA_W'($urandom));
    fill_run(DEPTH, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    fill_entry(1'b0, DATA_W'($urandom));
    fill_run(10, 1'b0, 1'b1);
    for (int a = 0; a <= 10; a++) begin
      drive_tick(2'b00, ADDR_W'(a), 1'b0, '0);
      checks++;
      if ({bus.addr_o, bus.q, bus.write_o} !== {m_addr, m_q, m_wr}) begin
        errors++;
        $display("FAIL abort_readback[%0d]: got addr=%0d q=%h wr=%b, required addr=%0d q=%h wr=%b",
                 a, bus.addr_o, bus.q, bus.write_o, m_addr, m_q, m_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_then_scan();
    test_manual();
    test_out_of_range();
    test_hold();
    test_back_to_back();
    test_start_on_tick();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
